// File: rtl/split_slave.sv
// Word-addressed memory slave for the system bus. Answers transfers with OKAY/ERROR/RETRY/SPLIT
// and can finish one long read in the background while the bus serves other masters.
module split_slave #(
  parameter int MEM_AW       = 8,
  parameter int WRITE_LAT    = 2,
  parameter int READ_LAT     = 6,
  parameter int SPLIT_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [13:0] HADDR,
  input  logic        hwrite,
  input  logic [31:0] WDATA,
  input  logic [1:0]  sb_masters,
  input  logic        sb_mastlock,
  output logic [31:0] RDATA,
  output logic [1:0]  resp,
  output logic        ready,
  output logic [1:0]  sb_split_ar
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} bus_state_t;
  typedef enum logic [1:0] {SPLIT_NONE, SPLIT_BG, SPLIT_HOLD} split_state_t;
  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_t;

  localparam int MAX_LAT = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
  localparam int CW      = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
  localparam bit SPLIT_ALLOWED = (READ_LAT > SPLIT_THRESH);

  logic [31:0] mem [2**MEM_AW];

  bus_state_t        state;
  split_state_t      split_st;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     bg_cnt;
  logic [MEM_AW-1:0] req_addr;
  logic              req_write;
  logic [31:0]       req_wdata;
  resp_t             req_resp;
  logic              req_held;
  logic [1:0]        split_master;
  logic [MEM_AW-1:0] split_addr;
  logic [31:0]       held_data;

  logic [MEM_AW-1:0] word;
  logic [11:0]       local_field;
  logic              addr_oob;
  logic              split_match;
  logic              accept;
  logic              mem_we;
  logic [31:0]       rsp_data;
  logic              unused_addr_hi;

  resp_t         acc_resp;
  logic [CW-1:0] acc_load;
  logic          acc_split;
  logic          acc_clear;

  assign word           = HADDR[MEM_AW-1:0];
  assign local_field    = HADDR[11:0];
  assign addr_oob       = (local_field >> MEM_AW) != 12'd0;
  assign unused_addr_hi = ^HADDR[13:12];
  assign accept         = (state == IDLE) && sel;

  // Only a held (already sampled) split may be handed back; during SPLIT_BG the owner gets RETRY.
  assign split_match = (split_st == SPLIT_HOLD) && (sb_masters == split_master) &&
                       !hwrite && (word == split_addr);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_resp  = RESP_OKAY;
    acc_load  = '0;
    acc_split = 1'b0;
    acc_clear = 1'b0;
    if (sb_masters == 2'b00 || addr_oob) begin
      acc_resp = RESP_ERROR;
    end else if (split_st != SPLIT_NONE && !split_match) begin
      acc_resp = RESP_RETRY;
    end else if (split_st != SPLIT_NONE) begin
      acc_clear = 1'b1;
    end else if (hwrite) begin
      acc_load = WR_LOAD;
    end else if (sb_mastlock || !SPLIT_ALLOWED) begin
      acc_load = RD_LOAD;
    end else begin
      acc_resp  = RESP_SPLIT;
      acc_split = 1'b1;
    end
  end

  assign mem_we = !rst && (state == BUSY) && (cnt == '0) && req_write && (req_resp == RESP_OKAY);

  always_comb begin
    rsp_data = 32'd0;
    if (req_resp == RESP_OKAY && !req_write)
      rsp_data = req_held ? held_data : mem[req_addr];
  end

  // NOTE: the memory array has no reset; only its write enable is qualified by rst.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[req_addr] <= req_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      split_st     <= SPLIT_NONE;
      cnt          <= '0;
      bg_cnt       <= '0;
      req_addr     <= '0;
      req_write    <= 1'b0;
      req_wdata    <= 32'd0;
      req_resp     <= RESP_OKAY;
      req_held     <= 1'b0;
      split_master <= 2'b00;
      split_addr   <= '0;
      held_data    <= 32'd0;
      RDATA        <= 32'd0;
      resp         <= RESP_OKAY;
      ready        <= 1'b0;
      sb_split_ar  <= 2'b00;
    end else begin
      sb_split_ar <= 2'b00;

      case (state)
        IDLE: begin
          if (sel) begin
            req_addr  <= word;
            req_write <= hwrite;
            req_wdata <= WDATA;
            req_resp  <= acc_resp;
            req_held  <= acc_clear;
            cnt       <= acc_load;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            ready <= 1'b1;
            resp  <= req_resp;
            RDATA <= rsp_data;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          ready <= 1'b0;
          resp  <= RESP_OKAY;
          RDATA <= 32'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Background read runs independently of whatever the bus side is serving.
      if (split_st == SPLIT_BG) begin
        if (bg_cnt == '0) begin
          held_data   <= mem[split_addr];
          sb_split_ar <= split_master;
          split_st    <= SPLIT_HOLD;
        end else begin
          bg_cnt <= bg_cnt - 1'b1;
        end
      end

      if (accept && acc_split) begin
        split_st     <= SPLIT_BG;
        split_master <= sb_masters;
        split_addr   <= word;
        bg_cnt       <= RD_LOAD;
      end else if (accept && acc_clear) begin
        split_st <= SPLIT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_split_slave.sv
// Scoreboard bench for split_slave: the driver queues expected responses and re-grant pulses,
// a negedge monitor pops and compares them as the DUTs present ready / sb_split_ar.
module tb_split_slave;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'b00;
  logic [13:0] haddr = 14'd0;
  logic        hwrite = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  masters = 2'b00;
  logic        lock = 1'b0;
  logic [31:0] rdata [2];
  logic [1:0]  resp [2];
  logic [1:0]  ready;
  logic [1:0]  split_ar [2];

  always #5 clk = ~clk;

  split_slave dut0 (
    .clk(clk), .rst(rst), .sel(sel[0]), .HADDR(haddr), .hwrite(hwrite), .WDATA(wdata),
    .sb_masters(masters), .sb_mastlock(lock),
    .RDATA(rdata[0]), .resp(resp[0]), .ready(ready[0]), .sb_split_ar(split_ar[0])
  );

  split_slave #(.READ_LAT(3), .SPLIT_THRESH(3)) dut1 (
    .clk(clk), .rst(rst), .sel(sel[1]), .HADDR(haddr), .hwrite(hwrite), .WDATA(wdata),
    .sb_masters(masters), .sb_mastlock(lock),
    .RDATA(rdata[1]), .resp(resp[1]), .ready(ready[1]), .sb_split_ar(split_ar[1])
  );

  typedef struct {
    int          inst;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          due;
    int          tag;
  } rsp_t;

  typedef struct {
    int         inst;
    logic [1:0] code;
    int         due;
  } ar_t;

  rsp_t rsp_q[$];
  ar_t  ar_q[$];
  rsp_t mon_rsp;
  ar_t  mon_ar;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ar(input int inst, input logic [1:0] code, input int lat);
    ar_t e;
    e.inst = inst;
    e.code = code;
    e.due  = cyc + 1 + lat;
    ar_q.push_back(e);
  endtask

  // Called #1 after a posedge; the next posedge is the accepting edge.
  task automatic xfer(input int inst, input logic [13:0] a, input logic w, input logic [31:0] wd,
                      input logic [1:0] m, input logic lk, input logic [1:0] er,
                      input logic [31:0] ed, input int lat, input int tag);
    rsp_t e;
    int   waited;
    haddr   = a;
    hwrite  = w;
    wdata   = wd;
    masters = m;
    lock    = lk;
    sel[inst] = 1'b1;
    e.inst  = inst;
    e.resp  = er;
    e.rdata = ed;
    e.due   = cyc + 1 + lat;
    e.tag   = tag;
    rsp_q.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ready[inst] !== 1'b1 && waited < 40);
    if (ready[inst] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL xfer%0d_timeout: no ready within %0d cycles", tag, waited);
    end
    @(posedge clk);
    #1;
    sel[inst] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ready[i] === 1'b1) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: inst%0d resp=%b rdata=%h", i, resp[i], rdata[i]);
        end else begin
          mon_rsp = rsp_q.pop_front();
          check($sformatf("xfer%0d_inst", mon_rsp.tag), 64'(i), 64'(mon_rsp.inst));
          check($sformatf("xfer%0d_resp", mon_rsp.tag), 64'(resp[i]), 64'(mon_rsp.resp));
          check($sformatf("xfer%0d_rdata", mon_rsp.tag), 64'(rdata[i]), 64'(mon_rsp.rdata));
          check($sformatf("xfer%0d_latency", mon_rsp.tag), 64'(cyc), 64'(mon_rsp.due));
        end
      end else begin
        check($sformatf("inst%0d_idle_outputs", i), 64'({resp[i], rdata[i]}), 64'(0));
      end
      if (split_ar[i] !== 2'b00) begin
        if (ar_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_split_ar: inst%0d code=%b cycle %0d", i, split_ar[i], cyc);
        end else begin
          mon_ar = ar_q.pop_front();
          check("split_ar_inst", 64'(i), 64'(mon_ar.inst));
          check("split_ar_code", 64'(split_ar[i]), 64'(mon_ar.code));
          check("split_ar_cycle", 64'(cyc), 64'(mon_ar.due));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_resp", 64'(resp[0]), 64'(0));
    check("reset_rdata", 64'(rdata[0]), 64'(0));
    check("reset_split_ar", 64'(split_ar[0]), 64'(0));
    rst = 1'b0;
    wait_cycles(1);

    // Write then locked read-back.
    xfer(0, 14'h005, 1'b1, 32'hDEADBEEF, 2'b01, 1'b0, OKAY, 32'h0, 2, 1);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b01, 1'b1, OKAY, 32'hDEADBEEF, 6, 2);

    // Unlocked read splits; other masters retried while the background read runs.
    expect_ar(0, 2'b01, 6);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b01, 1'b0, SPLIT, 32'h0, 1, 3);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b10, 1'b0, RETRY, 32'h0, 1, 4);
    xfer(0, 14'h005, 1'b1, 32'h12345678, 2'b10, 1'b0, RETRY, 32'h0, 1, 5);
    xfer(0, 14'h006, 1'b0, 32'h0, 2'b01, 1'b0, RETRY, 32'h0, 1, 6);
    xfer(0, 14'h005, 1'b1, 32'h0BADF00D, 2'b01, 1'b0, RETRY, 32'h0, 1, 7);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b01, 1'b0, OKAY, 32'hDEADBEEF, 1, 8);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b10, 1'b1, OKAY, 32'hDEADBEEF, 6, 9);

    // Decode errors, no-owner error, top-word boundary, memory unchanged.
    xfer(0, 14'h0100, 1'b0, 32'h0, 2'b01, 1'b0, ERROR, 32'h0, 1, 10);
    xfer(0, 14'h0105, 1'b1, 32'h0BAD0BAD, 2'b01, 1'b0, ERROR, 32'h0, 1, 11);
    xfer(0, 14'h005, 1'b1, 32'h0BAD0BAD, 2'b00, 1'b0, ERROR, 32'h0, 1, 12);
    xfer(0, 14'h0FF, 1'b1, 32'hA5A55A5A, 2'b10, 1'b0, OKAY, 32'h0, 2, 13);
    xfer(0, 14'h0FF, 1'b0, 32'h0, 2'b10, 1'b1, OKAY, 32'hA5A55A5A, 6, 14);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b01, 1'b1, OKAY, 32'hDEADBEEF, 6, 15);

    // Reset three cycles into the background read: no re-grant, no stale split.
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b01, 1'b0, SPLIT, 32'h0, 1, 16);
    rst = 1'b1;
    wait_cycles(1);
    check("midsplit_reset_ready", 64'(ready), 64'(0));
    check("midsplit_reset_resp", 64'(resp[0]), 64'(0));
    check("midsplit_reset_split_ar", 64'(split_ar[0]), 64'(0));
    rst = 1'b0;
    wait_cycles(8);
    expect_ar(0, 2'b10, 6);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b10, 1'b0, SPLIT, 32'h0, 1, 17);
    wait_cycles(6);
    xfer(0, 14'h005, 1'b0, 32'h0, 2'b10, 1'b0, OKAY, 32'hDEADBEEF, 1, 18);

    // READ_LAT == SPLIT_THRESH: unlocked read is served directly.
    xfer(1, 14'h010, 1'b1, 32'hCAFEF00D, 2'b01, 1'b0, OKAY, 32'h0, 2, 19);
    xfer(1, 14'h010, 1'b0, 32'h0, 2'b01, 1'b0, OKAY, 32'hCAFEF00D, 3, 20);

    wait_cycles(10);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
    check("split_ar_queue_drained", 64'(ar_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
